// File: rtl/itm_trace_arbiter.sv
// itm_trace_arbiter: per-channel trace FIFOs with drop counting, round-robin
// grant and a single registered valid/ready output stage.
// Ports: clk, rst (async active-low), cfg_enable, trace_in/trace_in_valid
// (NUM_CH sources), out_data/out_ch/out_lost/out_valid/out_ready, ovf_cnt.

`ifndef DBG_TIMESTAMP_WIDTH
`define DBG_TIMESTAMP_WIDTH 32
`endif

module itm_trace_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int TS_WIDTH   = `DBG_TIMESTAMP_WIDTH,
    parameter int FIFO_DEPTH = 4,
    localparam int W         = TS_WIDTH + 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_enable,
    input  logic [NUM_CH*W-1:0] trace_in,
    input  logic [NUM_CH-1:0]   trace_in_valid,
    output logic [W-1:0]        out_data,
    output logic [2:0]          out_ch,
    output logic                out_lost,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_CH*8-1:0] ovf_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NUM_CH);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t state;
    state_t state_nxt;

    logic [W:0]    mem    [NUM_CH][FIFO_DEPTH];
    logic [AW:0]   wr_ptr [NUM_CH];
    logic [AW:0]   rd_ptr [NUM_CH];
    logic [7:0]    cnt    [NUM_CH];
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] lost_pend;
    logic [CW-1:0] last_grant;
    logic [CW-1:0] grant;
    logic          any;
    logic          load;
    logic [W:0]    head;

    assign out_valid = (state == HOLD);
    assign load      = !out_valid || out_ready;
    assign head      = mem[grant][rd_ptr[grant][AW-1:0]];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign empty[i] = (wr_ptr[i] == rd_ptr[i]);
        // Full when the wrap bits differ but the index bits match.
        assign full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                          (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        assign pop[i]   = load && any && (grant == CW'(i));
        // A pop in the same cycle frees the slot a full FIFO needs.
        assign push[i]  = cfg_enable && trace_in_valid[i] &&
                          (!full[i] || pop[i]);
        assign drop[i]  = cfg_enable && trace_in_valid[i] &&
                          full[i] && !pop[i];
        assign ovf_cnt[i*8 +: 8] = cnt[i];
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int c;
        logic [CW-1:0] idx;
        grant = last_grant;
        any   = 1'b0;
        c     = 0;
        idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = int'(last_grant) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            idx = CW'(c);
            if (!any && !empty[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= {lost_pend[i], trace_in[i*W +: W]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lost_pend <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (drop[i]) begin
                    lost_pend[i] <= 1'b1;
                    if (cnt[i] != 8'hff) cnt[i] <= cnt[i] + 8'd1;
                end else if (push[i]) begin
                    lost_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = any ? HOLD : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data   <= '0;
            out_ch     <= '0;
            out_lost   <= 1'b0;
            last_grant <= CW'(NUM_CH - 1);
        end else if (load && any) begin
            out_data   <= head[W-1:0];
            out_lost   <= head[W];
            out_ch     <= 3'(grant);
            last_grant <= grant;
        end
    end

endmodule
